// File: rtl/dff_cell.sv
// rtl/dff_cell.sv - parameterised D flop / register / fixed-latency delay line
// Asynchronous active-low clear loads RESET_VAL into every stage.
module dff_cell #(
  parameter int              WIDTH     = 1,
  parameter int              STAGES    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "dff_cell: WIDTH must be at least 1");
  end

  if (STAGES < 1) begin : g_bad_stages
    $fatal(1, "dff_cell: STAGES must be at least 1");
  end

  // Each stage owns its register; stage 0 is fed from d, later stages from their predecessor.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] r_q;

    if (g == 0) begin : g_first
      assign w_src = d;
    end else begin : g_chain
      assign w_src = g_stage[g-1].r_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_q <= RESET_VAL;
      end else begin
        r_q <= w_src;
      end
    end
  end

  assign q = g_stage[STAGES-1].r_q;

endmodule

// File: tb/tb_dff_cell.sv
// tb/tb_dff_cell.sv - scoreboard bench for dff_cell in three configurations
// Reference model keeps the history of sampled values since the last reset.
module tb_dff_cell;

  logic       clk;
  logic       rst;
  logic       d1;
  logic       q1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [3:0] d4;
  logic [3:0] q4;

  dff_cell u_d1 (
    .clk (clk),
    .rst (rst),
    .d   (d1),
    .q   (q1)
  );

  dff_cell #(.WIDTH(8), .STAGES(1), .RESET_VAL(8'hA5)) u_d8 (
    .clk (clk),
    .rst (rst),
    .d   (d8),
    .q   (q8)
  );

  dff_cell #(.WIDTH(4), .STAGES(3), .RESET_VAL(4'h0)) u_d4 (
    .clk (clk),
    .rst (rst),
    .d   (d4),
    .q   (q4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] h1[$];
  logic [7:0] h8[$];
  logic [7:0] h4[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  event       mid_ev;
  string      dut_name[3] = '{"w1_s1", "w8_s1_a5", "w4_s3"};

  // A value reaches q on the n-th edge after it was sampled; before that q shows the reset value.
  function automatic logic [7:0] model_q(input logic [7:0] h[$], input int n, input logic [7:0] rv);
    if (h.size() >= n) return h[h.size() - n];
    return rv;
  endfunction

  task automatic push_exp();
    sb.push_back('{0, model_q(h1, 1, 8'h00)});
    sb.push_back('{1, model_q(h8, 1, 8'hA5)});
    sb.push_back('{2, model_q(h4, 3, 8'h00)});
  endtask

  task automatic clr_model();
    h1.delete();
    h8.delete();
    h4.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      h1.push_back({7'b0, d1});
      h8.push_back(d8);
      h4.push_back({4'b0, d4});
    end
    push_exp();
  endtask

  task automatic probe();
    push_exp();
    -> mid_ev;
    #2;
  endtask

  task automatic assert_rst_mid();
    rst = 1'b0;
    clr_model();
    probe();
  endtask

  task automatic reset_at_edge();
    @(posedge clk);
    rst = 1'b0;
    clr_model();
    push_exp();
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clk or mid_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.id)
          0:       act = {7'b0, q1};
          1:       act = q8;
          default: act = {4'b0, q4};
        endcase
        n_tests++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s t=%0t: q=%h expected %h", dut_name[e.id], $time, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst = 1'b1;
    d1  = 1'b0;
    d8  = 8'h00;
    d4  = 4'h0;
    #1;
    assert_rst_mid();

    n_tests++;
    if (q1 !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_s1 t=%0t: q=%h expected 0 in reset", $time, q1);
    end
    n_tests++;
    if (q8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL w8_s1_a5 t=%0t: q=%h expected a5 in reset", $time, q8);
    end
    n_tests++;
    if (q4 !== 4'h0) begin
      n_fail++;
      $display("FAIL w4_s3 t=%0t: q=%h expected 0 in reset", $time, q4);
    end

    // Reset hold with data toggling across edges.
    for (int i = 0; i < 3; i++) begin
      d1 = (i % 2 == 0);
      d8 = 8'($urandom);
      d4 = 4'($urandom);
      tick();
      #2;
      probe();
    end
    rst = 1'b1;
    probe();

    // Capture sequence with d changes between edges.
    d1 = 1'b1;
    tick();
    #10;
    d1 = 1'b0;
    probe();
    tick();
    #7;
    d1 = 1'b1;
    probe();
    #8;
    d1 = 1'b0;
    probe();
    tick();
    #2;
    d1 = 1'b1;
    d8 = 8'h3C;
    probe();
    tick();

    // Asynchronous clear between edges, then release before the next edge.
    #5;
    assert_rst_mid();
    #8;
    rst = 1'b1;
    d1  = 1'b1;
    d8  = 8'h3C;
    probe();
    tick();

    // Delay line fill, then a mid-stream clear whose data must never emerge.
    for (int i = 1; i <= 4; i++) begin
      #2;
      d4 = 4'(i);
      probe();
      tick();
    end
    for (int i = 5; i <= 6; i++) begin
      #2;
      d4 = 4'(i);
      tick();
    end
    #4;
    assert_rst_mid();
    rst = 1'b1;
    probe();
    for (int i = 9; i <= 13; i++) begin
      #2;
      d4 = 4'(i);
      tick();
    end

    // Reset coincident with a rising edge while d = 1.
    #2;
    d1 = 1'b1;
    d8 = 8'hFF;
    d4 = 4'hF;
    reset_at_edge();
    #3;
    probe();

    n_tests++;
    if (q1 !== 1'b0) begin
      n_fail++;
      $display("FAIL w1_s1 t=%0t: q=%h expected 0 after reset at edge", $time, q1);
    end
    n_tests++;
    if (q8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL w8_s1_a5 t=%0t: q=%h expected a5 after reset at edge", $time, q8);
    end
    n_tests++;
    if (q4 !== 4'h0) begin
      n_fail++;
      $display("FAIL w4_s3 t=%0t: q=%h expected 0 after reset at edge", $time, q4);
    end

    rst = 1'b1;
    probe();

    // Randomised traffic with glitches and occasional asynchronous clears.
    for (int i = 0; i < 300; i++) begin
      d1 = 1'($urandom);
      d8 = 8'($urandom);
      d4 = 4'($urandom);
      tick();
      #3;
      if ($urandom_range(0, 3) == 0) begin
        d1 = 1'($urandom);
        d8 = 8'($urandom);
        d4 = 4'($urandom);
        probe();
      end
      if ($urandom_range(0, 15) == 0) begin
        assert_rst_mid();
        #3;
        rst = 1'b1;
        probe();
      end
    end

    #5;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
